multi_process_int_arbiter: RTL

Collects per-engine completion interrupt requests from the ENGINE_NUM kernels of the multi-process framework and serializes them onto the single action interrupt handshake (o_interrupt / i_interrupt_ack) toward the OCACCEL core. One request is in flight at a time, with round-robin fairness across engines. Each request carries the engine's context and source code, and the block returns a one-cycle completion pulse to the serviced engine. It sits between the engine array and the action's top-level interrupt ports.

---
 rtl/multi_process_int_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/multi_process_int_arbiter.sv
// rtl/multi_process_int_arbiter.sv - round-robin serializer of engine completion interrupts onto one ack handshake
module multi_process_int_arbiter #(
    parameter int ENGINE_NUM   = 8,
    parameter int CONTEXT_BITS = 8,
    parameter int INT_BITS     = 3,
    parameter int ACK_TIMEOUT  = 65535
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ENGINE_NUM-1:0]          i_engine_int_req,
    input  logic [ENGINE_NUM*CONTEXT_BITS-1:0] i_engine_int_ctx,
    input  logic [ENGINE_NUM*INT_BITS-1:0] i_engine_int_src,
    input  logic [ENGINE_NUM-1:0]          i_int_enable,
    output logic [ENGINE_NUM-1:0]          o_engine_int_done,
    output logic                           o_interrupt,
    output logic [CONTEXT_BITS-1:0]        o_interrupt_ctx,
    output logic [INT_BITS-1:0]            o_interrupt_src,
    input  logic                           i_interrupt_ack,
    output logic                           o_ack_timeout,
    input  logic                           i_clear_timeout,
    output logic                           o_busy
);
    localparam int IDX_W = (ENGINE_NUM > 1) ? $clog2(ENGINE_NUM) : 1;
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

    state_t                  r_state;
    logic [IDX_W-1:0]        r_last_grant;
    logic [IDX_W-1:0]        r_winner;
    logic [CNT_W-1:0]        r_cnt;
    logic [ENGINE_NUM-1:0]   r_done;
    logic                    r_interrupt;
    logic [CONTEXT_BITS-1:0] r_ctx;
    logic [INT_BITS-1:0]     r_src;
    logic                    r_timeout;
    logic                    r_busy;

    logic [ENGINE_NUM-1:0]   w_eligible;
    logic                    w_found;
    logic [IDX_W-1:0]        w_pick;
    logic                    w_timeout_hit;

    assign w_eligible = i_engine_int_req & i_int_enable;

    // Walk offsets from farthest to nearest so the engine closest after last_grant wins.
    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = ENGINE_NUM; i >= 1; i--) begin
            idx = (int'(r_last_grant) + i) % ENGINE_NUM;
            if (w_eligible[idx]) begin
                w_found = 1'b1;
                w_pick  = IDX_W'(idx);
            end
        end
    end

    // Flag sets only on the cycle the counter crosses the limit, so a clear sticks afterwards.
    assign w_timeout_hit = (r_state == S_ISSUE) && !i_interrupt_ack &&
                           (r_cnt == CNT_W'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= IDX_W'(ENGINE_NUM - 1);
            r_winner     <= '0;
            r_cnt        <= '0;
            r_done       <= '0;
            r_interrupt  <= 1'b0;
            r_ctx        <= '0;
            r_src        <= '0;
            r_timeout    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_done <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_winner    <= w_pick;
                        r_ctx       <= i_engine_int_ctx[w_pick*CONTEXT_BITS +: CONTEXT_BITS];
                        r_src       <= i_engine_int_src[w_pick*INT_BITS +: INT_BITS];
                        r_interrupt <= 1'b1;
                        r_cnt       <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (i_interrupt_ack) begin
                        r_interrupt  <= 1'b0;
                        r_done       <= ENGINE_NUM'(1) << r_winner;
                        r_last_grant <= r_winner;
                        r_state      <= S_DONE;
                    end else if (r_cnt != CNT_W'(ACK_TIMEOUT)) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_timeout_hit)
                r_timeout <= 1'b1;
            else if (i_clear_timeout)
                r_timeout <= 1'b0;
        end
    end

    assign o_engine_int_done = r_done;
    assign o_interrupt       = r_interrupt;
    assign o_interrupt_ctx   = r_ctx;
    assign o_interrupt_src   = r_src;
    assign o_ack_timeout     = r_timeout;
    assign o_busy            = r_busy;
endmodule
